// File: rtl/board_pkg.sv
// board_pkg: shared constants, cell/result encodings and FSM states for the board controller
package board_pkg;
  localparam int CELLS = 100;
  localparam int AW = 7;
  localparam int DW = 2;
  localparam int MAX_SHIPS = 17;
  localparam logic [AW-1:0] CELLS_A = AW'(CELLS);
  localparam logic [AW-1:0] CELL_LAST = AW'(CELLS - 1);
  localparam logic [4:0] MAX_CNT = 5'(MAX_SHIPS);
  typedef enum logic [1:0] {EMPTY = 2'b00, SHIP = 2'b01, MISS = 2'b10, HIT = 2'b11} cell_t;
  typedef enum logic [1:0] {R_MISS = 2'b00, R_HIT = 2'b01, R_REPEAT = 2'b10, R_INVALID = 2'b11} fire_res_t;
  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_FRD, S_FEV, S_FWR, S_PRD, S_PEV, S_PWR, S_VRD, S_VEV, S_RSP
  } state_t;
endpackage

// File: rtl/board_sweep.sv
// board_sweep: clear-sweep address counter, restarted by start, done on the last cell
module board_sweep
  import board_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          en,
  output logic [AW-1:0] addr,
  output logic          done
);
  always_ff @(posedge clk) addr <= (rst || start) ? '0 : en ? addr + 1'b1 : addr;
  assign done = en && addr == CELL_LAST;
endmodule

// File: rtl/board_ctrl.sv
// board_ctrl: board memory sequencer/arbiter for clear, placement, firing and VGA reads
module board_ctrl
  import board_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic          mem_oe,
  inout  wire  [DW-1:0] mem_data,
  input  logic          clear_req,
  input  logic          place_req,
  input  logic [AW-1:0] place_addr,
  output logic          place_done,
  output logic          place_ok,
  input  logic          fire_req,
  input  logic [AW-1:0] fire_addr,
  output logic          fire_done,
  output logic [1:0]    fire_result,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic          vga_valid,
  output logic [DW-1:0] vga_data,
  output logic          ready,
  output logic [4:0]    ship_cnt,
  output logic [4:0]    hit_cnt,
  output logic          game_over
);
  state_t state, state_d;
  cell_t wr_q, wr_d, rd;
  fire_res_t fire_result_d;
  logic [AW-1:0] addr_q, addr_d, sweep_addr;
  logic [DW-1:0] vga_data_d;
  logic sweep_start, sweep_done, fire_done_d, place_done_d, place_ok_d, vga_valid_d;
  logic hit_inc, ship_inc, cnt_clr;
  board_sweep u_sweep (
    .clk  (clk),
    .rst  (rst),
    .start(sweep_start),
    .en   (state == S_CLEAR),
    .addr (sweep_addr),
    .done (sweep_done)
  );
  assign rd = cell_t'(mem_data);
  assign ready = !rst && state == S_IDLE;
  assign mem_we = !rst && (state inside {S_CLEAR, S_FWR, S_PWR});
  assign mem_oe = !rst && (state inside {S_FRD, S_PRD, S_VRD});
  assign mem_addr = state == S_CLEAR ? sweep_addr : addr_q;
  assign mem_data = mem_we ? (state == S_CLEAR ? EMPTY : wr_q) : 'z;
  assign game_over = ship_cnt != '0 && hit_cnt == ship_cnt;
  always_comb begin
    state_d = state;
    addr_d = addr_q;
    wr_d = wr_q;
    vga_data_d = vga_data;
    fire_result_d = R_MISS;
    sweep_start = 1'b0;
    fire_done_d = 1'b0;
    place_done_d = 1'b0;
    place_ok_d = 1'b0;
    vga_valid_d = 1'b0;
    hit_inc = 1'b0;
    ship_inc = 1'b0;
    cnt_clr = 1'b0;
    case (state)
      S_IDLE: begin
        if (clear_req) begin
          state_d = S_CLEAR;
          sweep_start = 1'b1;
          cnt_clr = 1'b1;
        end else if (fire_req) begin
          addr_d = fire_addr;
          state_d = fire_addr < CELLS_A ? S_FRD : S_RSP;
          fire_done_d = fire_addr >= CELLS_A;
          fire_result_d = fire_addr < CELLS_A ? R_MISS : R_INVALID;
        end else if (place_req) begin
          addr_d = place_addr;
          state_d = place_addr < CELLS_A ? S_PRD : S_RSP;
          place_done_d = place_addr >= CELLS_A;
        end else if (vga_req) begin
          addr_d = vga_addr;
          state_d = vga_addr < CELLS_A ? S_VRD : S_RSP;
          vga_valid_d = vga_addr >= CELLS_A;
          vga_data_d = vga_addr < CELLS_A ? vga_data : EMPTY;
        end
      end
      S_CLEAR: state_d = sweep_done ? S_IDLE : S_CLEAR;
      S_FRD: state_d = S_FEV;
      S_FEV: begin
        if (rd == SHIP || rd == EMPTY) begin
          state_d = S_FWR;
          wr_d = rd == SHIP ? HIT : MISS;
        end else begin
          state_d = S_RSP;
          fire_done_d = 1'b1;
          fire_result_d = R_REPEAT;
        end
      end
      S_FWR: begin
        state_d = S_RSP;
        fire_done_d = 1'b1;
        fire_result_d = wr_q == HIT ? R_HIT : R_MISS;
        hit_inc = wr_q == HIT;
      end
      S_PRD: state_d = S_PEV;
      S_PEV: begin
        if (rd == EMPTY && ship_cnt < MAX_CNT) begin
          state_d = S_PWR;
          wr_d = SHIP;
        end else begin
          state_d = S_RSP;
          place_done_d = 1'b1;
        end
      end
      S_PWR: begin
        state_d = S_RSP;
        place_done_d = 1'b1;
        place_ok_d = 1'b1;
        ship_inc = 1'b1;
      end
      S_VRD: state_d = S_VEV;
      S_VEV: begin
        state_d = S_RSP;
        vga_valid_d = 1'b1;
        vga_data_d = rd;
      end
      S_RSP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= rst ? S_CLEAR : state_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      wr_q <= EMPTY;
      vga_data <= '0;
      fire_result <= '0;
      fire_done <= 1'b0;
      place_done <= 1'b0;
      place_ok <= 1'b0;
      vga_valid <= 1'b0;
      ship_cnt <= '0;
      hit_cnt <= '0;
    end else begin
      addr_q <= addr_d;
      wr_q <= wr_d;
      vga_data <= vga_data_d;
      fire_result <= fire_result_d;
      fire_done <= fire_done_d;
      place_done <= place_done_d;
      place_ok <= place_ok_d;
      vga_valid <= vga_valid_d;
      ship_cnt <= cnt_clr ? '0 : (ship_inc && ship_cnt < MAX_CNT) ? ship_cnt + 1'b1 : ship_cnt;
      hit_cnt <= cnt_clr ? '0 : (hit_inc && hit_cnt < MAX_CNT) ? hit_cnt + 1'b1 : hit_cnt;
    end
  end
endmodule
